// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, response codes and select-width helper for the APB requester
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // A single slave still gets a one-bit select field so slicing stays legal.
    function automatic int sel_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_master_nslave_if.sv
// rtl/apb_master_nslave_if.sv - request/response channels plus APB4 bus bundle
interface apb_master_nslave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                             req_valid;
    logic                             req_ready;
    logic                             req_write;
    logic [ADDR_WIDTH-1:0]            req_addr;
    logic [DATA_WIDTH-1:0]            req_wdata;
    logic [STRB_WIDTH-1:0]            req_strb;
    logic                             resp_valid;
    logic                             resp_ready;
    logic [DATA_WIDTH-1:0]            resp_rdata;
    logic                             resp_err;
    logic [NUM_SLAVES-1:0]            PSEL;
    logic                             PENABLE;
    logic                             PWRITE;
    logic [ADDR_WIDTH-1:0]            PADDR;
    logic [DATA_WIDTH-1:0]            PWDATA;
    logic [STRB_WIDTH-1:0]            PSTRB;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]            PREADY;
    logic [NUM_SLAVES-1:0]            PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, resp_ready,
               PRDATA, PREADY, PSLVERR,
        output req_ready, resp_valid, resp_rdata, resp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, resp_ready,
               PRDATA, PREADY, PSLVERR,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

endinterface

// File: rtl/apb_slave_decode.sv
// rtl/apb_slave_decode.sv - index to one-hot select, hit flag and per-slave return mux
module apb_slave_decode #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_BITS   = 2
) (
    input  logic [SEL_BITS-1:0]            idx,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]          pready,
    input  logic [NUM_SLAVES-1:0]          pslverr,
    output logic [NUM_SLAVES-1:0]          sel_onehot,
    output logic                           hit,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           ready,
    output logic                           slverr
);

    always_comb begin
        sel_onehot = '0;
        hit        = 1'b0;
        rdata      = '0;
        ready      = 1'b0;
        slverr     = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (32'(idx) == i) begin
                sel_onehot[i] = 1'b1;
                hit           = 1'b1;
                rdata         = prdata[i*DATA_WIDTH +: DATA_WIDTH];
                ready         = pready[i];
                slverr        = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/apb_master_nslave.sv
// rtl/apb_master_nslave.sv - APB4 requester with N-way slave decode; APB_TIMEOUT_EN adds an ACCESS wait limit
module apb_master_nslave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_master_nslave_if.master bus
);

    localparam int SEL_BITS   = sel_bits(NUM_SLAVES);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536)
    begin : g_bad_params
        $error("apb_master_nslave: parameter out of range");
    end

    apb_state_e            state, state_next;
    logic [SEL_BITS-1:0]   idx_q;
    logic [SEL_BITS-1:0]   dec_idx;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  accept;
    logic                  timeout;

    logic [NUM_SLAVES-1:0] dec_onehot;
    logic                  dec_hit;
    logic [DATA_WIDTH-1:0] dec_rdata;
    logic                  dec_ready;
    logic                  dec_slverr;

    // Decode the live request while idle, the captured index once a transfer is under way.
    assign dec_idx = (state == IDLE) ? bus.req_addr[SEL_LSB +: SEL_BITS] : idx_q;
    assign accept  = (state == IDLE) && bus.req_valid;

    apb_slave_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_BITS   (SEL_BITS)
    ) u_decode (
        .idx        (dec_idx),
        .prdata     (bus.PRDATA),
        .pready     (bus.PREADY),
        .pslverr    (bus.PSLVERR),
        .sel_onehot (dec_onehot),
        .hit        (dec_hit),
        .rdata      (dec_rdata),
        .ready      (dec_ready),
        .slverr     (dec_slverr)
    );

`ifdef APB_TIMEOUT_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !dec_ready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout = (state == ACCESS) && !dec_ready && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = dec_hit ? SETUP : RESP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (dec_ready || timeout) state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_q    <= '0;
            psel_q   <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    idx_q   <= dec_idx;
                    rdata_q <= '0;
                    if (dec_hit) begin
                        psel_q   <= dec_onehot;
                        pwrite_q <= bus.req_write;
                        paddr_q  <= bus.req_addr;
                        pwdata_q <= bus.req_wdata;
                        pstrb_q  <= bus.req_write ? bus.req_strb : '0;
                        err_q    <= RESP_OKAY;
                    end else begin
                        err_q <= RESP_ERR;
                    end
                end
                ACCESS: begin
                    if (dec_ready) begin
                        psel_q  <= '0;
                        rdata_q <= pwrite_q ? '0 : dec_rdata;
                        err_q   <= dec_slverr;
                    end else if (timeout) begin
                        psel_q  <= '0;
                        rdata_q <= '0;
                        err_q   <= RESP_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.PSEL       = psel_q;
    assign bus.PENABLE    = (state == ACCESS);
    assign bus.PWRITE     = pwrite_q;
    assign bus.PADDR      = paddr_q;
    assign bus.PWDATA     = pwdata_q;
    assign bus.PSTRB      = pstrb_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// tb/tb_apb_master_nslave.sv - directed self-checking bench for apb_master_nslave
module tb_apb_master_nslave;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_nslave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4)) bus4 ();
    apb_master_nslave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3)) bus3 ();

    apb_master_nslave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT_CYCLES(8)
    ) u_dut4 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus4)
    );

    apb_master_nslave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .SEL_LSB(12), .TIMEOUT_CYCLES(256)
    ) u_dut3 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic req4(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
        bus4.req_valid = 1'b1;
        bus4.req_write = wr;
        bus4.req_addr  = addr;
        bus4.req_wdata = wdata;
        bus4.req_strb  = strb;
    endtask

    int  pen;
    bit  strb_ok;

    initial begin
        bus4.req_valid = 0; bus4.req_write = 0; bus4.req_addr = '0; bus4.req_wdata = '0;
        bus4.req_strb = '0; bus4.resp_ready = 0; bus4.PRDATA = '0; bus4.PREADY = '0;
        bus4.PSLVERR = '0;
        bus3.req_valid = 0; bus3.req_write = 0; bus3.req_addr = '0; bus3.req_wdata = '0;
        bus3.req_strb = '0; bus3.resp_ready = 0; bus3.PRDATA = '0; bus3.PREADY = '0;
        bus3.PSLVERR = '0;
        repeat (3) tick();
        check("rst_req_ready", bus4.req_ready, 1);
        check("rst_psel", bus4.PSEL, 0);
        check("rst_penable", bus4.PENABLE, 0);
        check("rst_resp_valid", bus4.resp_valid, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();

        // zero-wait write to slave 2
        bus4.PREADY = 4'b0100;
        req4(1'b1, 32'h0000_2010, 32'hDEADBEEF, 4'hF);
        tick();
        bus4.req_valid = 0;
        check("wr_psel_setup", bus4.PSEL, 4'b0100);
        check("wr_penable_setup", bus4.PENABLE, 0);
        check("wr_req_ready_busy", bus4.req_ready, 0);
        check("wr_pwdata", bus4.PWDATA, 32'hDEADBEEF);
        check("wr_pstrb", bus4.PSTRB, 4'hF);
        check("wr_paddr", bus4.PADDR, 32'h0000_2010);
        check("wr_pwrite", bus4.PWRITE, 1);
        tick();
        check("wr_penable_access", bus4.PENABLE, 1);
        check("wr_psel_access", bus4.PSEL, 4'b0100);
        tick();
        check("wr_resp_valid", bus4.resp_valid, 1);
        check("wr_resp_err", bus4.resp_err, 0);
        check("wr_resp_rdata", bus4.resp_rdata, 0);
        check("wr_psel_done", bus4.PSEL, 0);
        check("wr_penable_done", bus4.PENABLE, 0);
        bus4.resp_ready = 1;
        tick();
        bus4.resp_ready = 0;
        check("wr_resp_consumed", bus4.resp_valid, 0);
        check("wr_req_ready_back", bus4.req_ready, 1);

        // read from slave 1 with three wait states; other slaves noisy
        bus4.PREADY = 4'b1101;
        bus4.PSLVERR = 4'b1101;
        bus4.PRDATA = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h1234_5678, 32'hCCCC_CCCC};
        req4(1'b0, 32'h0000_1004, 32'hFFFF_FFFF, 4'hF);
        tick();
        bus4.req_valid = 0;
        check("rd_psel", bus4.PSEL, 4'b0010);
        pen = 0;
        strb_ok = 1;
        for (int i = 0; i < 20 && !bus4.resp_valid; i++) begin
            if (pen == 3) bus4.PREADY = 4'b1111;
            if (bus4.PENABLE) pen++;
            if (bus4.PSTRB != 4'h0) strb_ok = 0;
            tick();
        end
        check("rd_penable_cycles", pen, 4);
        check("rd_pstrb_zero", strb_ok, 1);
        check("rd_resp_valid", bus4.resp_valid, 1);
        check("rd_resp_rdata", bus4.resp_rdata, 32'h1234_5678);
        check("rd_resp_err", bus4.resp_err, 0);
        bus4.resp_ready = 1;
        tick();
        bus4.resp_ready = 0;
        bus4.PSLVERR = '0;

        // decode miss on the three-slave instance
        bus3.PRDATA = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        bus3.PREADY = 3'b111;
        bus3.req_valid = 1; bus3.req_write = 0; bus3.req_addr = 32'h0000_3000;
        tick();
        bus3.req_valid = 0;
        check("miss_resp_valid", bus3.resp_valid, 1);
        check("miss_psel", bus3.PSEL, 0);
        check("miss_err", bus3.resp_err, 1);
        check("miss_rdata", bus3.resp_rdata, 0);
        check("miss_req_ready", bus3.req_ready, 0);
        bus3.resp_ready = 1;
        tick();
        bus3.resp_ready = 0;
        check("miss_idle", bus3.req_ready, 1);

        // slave error on a write, response backpressured
        bus4.PREADY = 4'b0001;
        bus4.PSLVERR = 4'b0001;
        req4(1'b1, 32'h0000_0000, 32'h0000_00FF, 4'h1);
        tick();
        bus4.req_valid = 0;
        tick();
        tick();
        check("slverr_resp_err", bus4.resp_err, 1);
        req4(1'b1, 32'h0000_2000, 32'h5555_AAAA, 4'h3);
        for (int i = 0; i < 5; i++) begin
            check("slverr_hold_valid", bus4.resp_valid, 1);
            check("slverr_hold_ready", bus4.req_ready, 0);
            tick();
        end
        bus4.resp_ready = 1;
        tick();
        bus4.resp_ready = 0;
        check("overlap_not_accepted", bus4.PSEL, 0);
        check("overlap_idle", bus4.req_ready, 1);
        bus4.PREADY = 4'b0100;
        bus4.PSLVERR = '0;
        tick();
        bus4.req_valid = 0;
        check("overlap_accept_psel", bus4.PSEL, 4'b0100);
        check("overlap_pstrb", bus4.PSTRB, 4'h3);
        tick();
        tick();
        check("overlap_resp_err", bus4.resp_err, 0);
        bus4.resp_ready = 1;
        tick();
        bus4.resp_ready = 0;

        // slave 3 never ready
        bus4.PREADY = 4'b0000;
        req4(1'b0, 32'h0000_3000, 32'h0, 4'h0);
        tick();
        bus4.req_valid = 0;
        pen = 0;
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 40 && !bus4.resp_valid; i++) begin
            if (bus4.PENABLE) pen++;
            tick();
        end
        check("to_penable_cycles", pen, 8);
        check("to_resp_valid", bus4.resp_valid, 1);
        check("to_psel", bus4.PSEL, 0);
        check("to_resp_err", bus4.resp_err, 1);
        check("to_resp_rdata", bus4.resp_rdata, 0);
        bus4.resp_ready = 1;
        tick();
        bus4.resp_ready = 0;
        req4(1'b0, 32'h0000_3000, 32'h0, 4'h0);
        tick();
        bus4.req_valid = 0;
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            if (bus4.PENABLE) pen++;
            tick();
        end
        check("noto_penable_cycles", pen, 99);
        check("noto_penable_still", bus4.PENABLE, 1);
        check("noto_resp_valid", bus4.resp_valid, 0);
`endif

        // reset in the middle of ACCESS
        check("prerst_in_access", bus4.PENABLE, 1);
        check("prerst_psel", bus4.PSEL, 4'b1000);
        #2;
        PRESETn = 1'b0;
        #1;
        check("midrst_psel", bus4.PSEL, 0);
        check("midrst_penable", bus4.PENABLE, 0);
        check("midrst_resp_valid", bus4.resp_valid, 0);
        check("midrst_req_ready", bus4.req_ready, 1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        bus4.PREADY = 4'b1111;
        bus4.PRDATA = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};
        req4(1'b0, 32'h0000_1008, 32'h0, 4'hF);
        tick();
        bus4.req_valid = 0;
        check("postrst_psel", bus4.PSEL, 4'b0010);
        tick();
        tick();
        check("postrst_resp_valid", bus4.resp_valid, 1);
        check("postrst_rdata", bus4.resp_rdata, 32'hCAFE_F00D);
        check("postrst_err", bus4.resp_err, 0);
        bus4.resp_ready = 1;
        tick();
        bus4.resp_ready = 0;
        check("postrst_idle", bus4.req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
